barrel_shift_pipe: RTL and testbench
====================================

// Module: barrel_shift_pipe
// PURPOSE
//   Parametrised, fully pipelined barrel shifter: one log2 shift stage per clock,
//   valid/ready handshake on input and output, bubble-collapsing backpressure.
//   Supports logical left, logical right, arithmetic right and rotate left.
//   Sits between operand register file and ALU result mux; 1 op/cycle sustained.
// PARAMETERS
//   WIDTH   16   data width; power of two, >= 2
//   SHW     $clog2(WIDTH)   shift-amount width and number of pipeline stages (derived, localparam)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active low
//   in_valid   in   1      input operand valid
//   in_ready   out  1      block accepts input this cycle
//   in_data    in   WIDTH  operand
//   in_shamt   in   SHW    shift amount, 0..WIDTH-1
//   in_mode    in   2      00 LSL, 01 LSR, 10 ASR, 11 ROL
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_data   out  WIDTH  shifted result
//   out_mode   out  2      mode that produced out_data
// BEHAVIOUR
//   - Stages s=0..SHW-1, each a register {v_s, data_s, shamt_s, mode_s}. Stage s applies
//     shift by 2^s when shamt bit s is 1, else passes data; stage SHW-1 drives out_*.
//   - Shift rules per stage: LSL fills zeros at LSB; LSR fills zeros at MSB; ASR fills
//     with the operand's original MSB (carried sign, not the current stage's MSB
//     re-evaluated); ROL wraps bits shifted out of MSB into LSB. Widths never grow.
//   - Handshake: transfer on valid&&ready. rdy_SHW = out_ready; rdy_s = !v_s || rdy_(s+1);
//     in_ready = rdy_0 (combinational chain, no register). Stage s loads from s-1 when
//     rdy_s; v_s <= v_(s-1) (v_-1 = in_valid). Bubbles collapse: empty stages fill even
//     while output stalls.
//   - Stall: while out_valid && !out_ready, out_data/out_mode held stable, no drop/dup.
//   - Latency: SHW cycles from input transfer to out_valid with no stall; throughput 1/cycle.
//   - Capacity SHW items; with out_ready low, in_ready falls after SHW accepts.
//   - in_shamt = 0: data passes unchanged in every mode (still SHW cycles latency).
//   - in_data/in_shamt/in_mode ignored when !in_valid; stage data is don't-care when v_s=0
//     but out_data must read 0 when out_valid=0 after reset until first result.
//   - Reset (rst_n low at a clock edge): all v_s=0, out_valid=0, out_data=0, out_mode=00,
//     in_ready=1 the cycle after release. In-flight ops are discarded; none emerge later.
//   - Simultaneous in transfer and out transfer in a full pipe: both occur, occupancy constant.
// TESTING (WIDTH=16, SHW=4)
//   1 LSL 0x8001 shamt 1, out_ready=1 -> out_data 0x0002, out_valid 4 cycles after accept.
//   2 LSR 0x8001 shamt 4 -> 0x0800; ASR 0x8000 shamt 15 -> 0xFFFF; ASR 0x4000 shamt 15 -> 0x0000.
//   3 ROL 0x8001 shamt 4 -> 0x0018; ROL 0x1234 shamt 0 -> 0x1234; ROL 0xF000 shamt 8 -> 0x00F0.
//   4 Stream 8 ops back-to-back, out_ready=1 -> 8 results in order on consecutive cycles.
//   5 out_ready=0 for 6 cycles during stream -> in_ready low after 4 accepts; out_data stable;
//     on out_ready=1 all ops emerge in order, none lost or duplicated.
//   6 rst_n low 1 cycle with 3 ops in flight -> out_valid 0 next cycle, in_ready 1, no stale
//     result ever appears; next op 0x00FF LSL 8 -> 0xFF00 after 4 cycles.

Source files
------------

// File: rtl/barrel_shift_pipe.sv
// ----------------------------------------------------------------------------
// barrel_shift_pipe
//   Fully pipelined barrel shifter with one log2 shift stage per clock. Stage s
//   shifts by 2^s when bit s of the operation's shift amount is set. Supports
//   logical left, logical right, arithmetic right and rotate left. A
//   valid/ready handshake on both sides lets empty stages fill while the
//   output is stalled, so bubbles collapse and one op per cycle is sustained.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active low
//   in_valid   in   1      input operand valid
//   in_ready   out  1      block accepts input this cycle (combinational)
//   in_data    in   WIDTH  operand
//   in_shamt   in   SHW    shift amount, 0..WIDTH-1
//   in_mode    in   2      00 LSL, 01 LSR, 10 ASR, 11 ROL
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_data   out  WIDTH  shifted result
//   out_mode   out  2      mode that produced out_data
// ----------------------------------------------------------------------------
module barrel_shift_pipe #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_shamt,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [1:0]                 out_mode
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // One shift step of a fixed distance. ASR fills with the operand's original
  // sign bit carried down the pipe, never with the current stage's MSB.
  // amt is always a power of two below WIDTH, so the rotate never wraps by 0.
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] d,
    input logic             en,
    input logic [1:0]       mode,
    input logic             sign,
    input int               amt
  );
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] fill;
    fill = sign ? ~({WIDTH{1'b1}} >> amt) : {WIDTH{1'b0}};
    if (en) begin
      case (mode)
        MODE_LSL: r = d << amt;
        MODE_LSR: r = d >> amt;
        MODE_ASR: r = (d >> amt) | fill;
        MODE_ROL: r = (d << amt) | (d >> (WIDTH - amt));
        default:  r = d;
      endcase
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Stage registers
  logic [SHW-1:0]    v_r;
  logic [WIDTH-1:0]  data_r  [SHW];
  logic [SHW-1:0]    shamt_r [SHW];
  logic [1:0]        mode_r  [SHW];
  logic [SHW-1:0]    sign_r;

  // Values each stage would load this cycle
  logic [SHW-1:0]    nxt_v_s;
  logic [WIDTH-1:0]  nxt_data_s  [SHW];
  logic [SHW-1:0]    nxt_shamt_s [SHW];
  logic [1:0]        nxt_mode_s  [SHW];
  logic [SHW-1:0]    nxt_sign_s;

  // rdy_s[s] : stage s may load this cycle; rdy_s[SHW] is the downstream ready
  logic [SHW:0]      rdy_s;

  // Ready chain: a stage can load if it is empty or its successor moves on
  always_comb begin
    rdy_s      = {(SHW+1){1'b0}};
    rdy_s[SHW] = out_ready;
    for (int s = SHW - 1; s >= 0; s--) begin
      rdy_s[s] = !v_r[s] || rdy_s[s+1];
    end
  end

  // Next-stage contents: stage 0 takes the input port, later stages their predecessor
  always_comb begin
    nxt_v_s       = {SHW{1'b0}};
    nxt_sign_s    = {SHW{1'b0}};
    nxt_v_s[0]    = in_valid;
    nxt_shamt_s[0] = in_shamt;
    nxt_mode_s[0] = in_mode;
    nxt_sign_s[0] = in_data[WIDTH-1];
    nxt_data_s[0] = stage_shift(in_data, in_shamt[0], in_mode, in_data[WIDTH-1], 1);
    for (int s = 1; s < SHW; s++) begin
      nxt_v_s[s]     = v_r[s-1];
      nxt_shamt_s[s] = shamt_r[s-1];
      nxt_mode_s[s]  = mode_r[s-1];
      nxt_sign_s[s]  = sign_r[s-1];
      nxt_data_s[s]  = stage_shift(data_r[s-1], shamt_r[s-1][s], mode_r[s-1],
                                   sign_r[s-1], int'(32'd1 << s));
    end
  end

  // Pipeline registers; payload only loads with a valid item so the output
  // keeps reading zero after reset until the first real result arrives
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_r    <= {SHW{1'b0}};
      sign_r <= {SHW{1'b0}};
      for (int s = 0; s < SHW; s++) begin
        data_r[s]  <= {WIDTH{1'b0}};
        shamt_r[s] <= {SHW{1'b0}};
        mode_r[s]  <= 2'b00;
      end
    end else begin
      for (int s = 0; s < SHW; s++) begin
        if (rdy_s[s]) begin
          v_r[s] <= nxt_v_s[s];
          if (nxt_v_s[s]) begin
            data_r[s]  <= nxt_data_s[s];
            shamt_r[s] <= nxt_shamt_s[s];
            mode_r[s]  <= nxt_mode_s[s];
            sign_r[s]  <= nxt_sign_s[s];
          end
        end
      end
    end
  end

  assign in_ready  = rdy_s[0];
  assign out_valid = v_r[SHW-1];
  assign out_data  = data_r[SHW-1];
  assign out_mode  = mode_r[SHW-1];

endmodule

// File: tb/tb_barrel_shift_pipe.sv
module tb_barrel_shift_pipe;

  localparam int WIDTH = 16;
  localparam int SHW   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [SHW-1:0]    in_shamt;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        out_mode;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       mode;
  } res_t;

  res_t exp_q[$];

  barrel_shift_pipe #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  // Reference: whole-word shift done in one step with plain operators
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                 input logic [SHW-1:0] sh,
                                                 input logic [1:0] m);
    logic [2*WIDTH-1:0] dbl;
    logic signed [WIDTH-1:0] sd;
    logic [WIDTH-1:0] r;
    sd  = d;
    dbl = {d, d} << sh;
    case (m)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = sd >>> sh;
      default: r = dbl[2*WIDTH-1:WIDTH];
    endcase
    return r;
  endfunction

  // Drive one cycle's inputs just after the falling edge, then settle
  task automatic tick(input logic rst, input logic v, input logic [WIDTH-1:0] d,
                      input logic [SHW-1:0] sh, input logic [1:0] m, input logic ordy);
    @(negedge clk);
    rst_n = rst; in_valid = v; in_data = d; in_shamt = sh; in_mode = m; out_ready = ordy;
    #1;
  endtask

  task automatic rand_tick(input logic v, input logic ordy);
    tick(1'b1, v, 16'($urandom), 4'($urandom), 2'($urandom), ordy);
  endtask

  // Record an accepted input in the scoreboard
  task automatic push_accept();
    res_t e;
    if (in_valid && in_ready) begin
      e.data = ref_shift(in_data, in_shamt, in_mode);
      e.mode = in_mode;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
    tick(1'b0, 1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
    tick(1'b1, 1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    checks++; if (out_mode !== 2'b00) begin failures++; $display("FAIL reset_out_mode got=%b exp=00", out_mode); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  // Send one op alone and check value, mode and latency against a fixed answer
  task automatic single_op(input string name, input logic [WIDTH-1:0] d, input logic [SHW-1:0] sh,
                           input logic [1:0] m, input logic [WIDTH-1:0] expect_d);
    int lat;
    logic [WIDTH-1:0] got_d;
    logic [1:0] got_m;
    lat = 0; got_d = 16'h0; got_m = 2'b00;
    tick(1'b1, 1'b1, d, sh, m, 1'b1);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_accept got=%b exp=1", name, in_ready); end
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      tick(1'b1, 1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
      if (out_valid === 1'b1) begin lat = c; got_d = out_data; got_m = out_mode; end
    end
    checks++; if (lat != 4) begin failures++; $display("FAIL %s_latency got=%0d exp=4", name, lat); end
    checks++; if (got_d !== expect_d) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, got_d, expect_d); end
    checks++; if (got_m !== m) begin failures++; $display("FAIL %s_mode got=%b exp=%b", name, got_m, m); end
  endtask

  task automatic test_directed();
    single_op("lsl_8001_1",  16'h8001, 4'd1,  2'b00, 16'h0002);
    single_op("lsr_8001_4",  16'h8001, 4'd4,  2'b01, 16'h0800);
    single_op("asr_8000_15", 16'h8000, 4'd15, 2'b10, 16'hFFFF);
    single_op("asr_4000_15", 16'h4000, 4'd15, 2'b10, 16'h0000);
    single_op("rol_8001_4",  16'h8001, 4'd4,  2'b11, 16'h0018);
    single_op("rol_1234_0",  16'h1234, 4'd0,  2'b11, 16'h1234);
    single_op("rol_f000_8",  16'hF000, 4'd8,  2'b11, 16'h00F0);
    single_op("lsr_abcd_0",  16'hABCD, 4'd0,  2'b01, 16'hABCD);
    single_op("asr_9234_3",  16'h9234, 4'd3,  2'b10, 16'hF246);
  endtask

  task automatic test_back_to_back();
    int sent, recv, last_t;
    res_t e;
    sent = 0; recv = 0; last_t = -1;
    for (int t = 0; t < 24; t++) begin
      rand_tick(sent < 8, 1'b1);
      if (sent < 8) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready t=%0d got=%b exp=1", t, in_ready); end
      end
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL b2b_stale t=%0d got=%h exp=none", t, out_data);
        end else begin
          e = exp_q.pop_front();
          checks++; if ({out_data, out_mode} !== {e.data, e.mode}) begin failures++;
            $display("FAIL b2b_data t=%0d got=%h/%b exp=%h/%b", t, out_data, out_mode, e.data, e.mode); end
          if (recv > 0) begin
            checks++; if (t != last_t + 1) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", t, last_t + 1); end
          end
          last_t = t; recv++;
        end
      end
      if (in_valid && in_ready) sent++;
      push_accept();
    end
    checks++; if (recv != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", recv); end
  endtask

  task automatic test_stall();
    int sent, recv;
    logic ordy, prev_stall;
    logic [WIDTH-1:0] prev_d;
    res_t e;
    sent = 0; recv = 0; prev_stall = 1'b0; prev_d = 16'h0;
    for (int t = 0; t < 60 && recv < 10; t++) begin
      ordy = (t >= 6);
      rand_tick(sent < 10, ordy);
      checks++; if (in_ready !== (ordy || exp_q.size() < SHW)) begin failures++;
        $display("FAIL stall_in_ready t=%0d got=%b exp=%b", t, in_ready, (ordy || exp_q.size() < SHW)); end
      if (t == 5) begin
        checks++; if (sent != 4) begin failures++; $display("FAIL stall_accepts got=%0d exp=4", sent); end
      end
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || out_data !== prev_d) begin failures++;
          $display("FAIL stall_hold t=%0d got=%b/%h exp=1/%h", t, out_valid, out_data, prev_d); end
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL stall_stale t=%0d got=%h exp=none", t, out_data);
        end else begin
          e = exp_q.pop_front();
          checks++; if ({out_data, out_mode} !== {e.data, e.mode}) begin failures++;
            $display("FAIL stall_data t=%0d got=%h/%b exp=%h/%b", t, out_data, out_mode, e.data, e.mode); end
          recv++;
        end
      end
      if (in_valid && in_ready) sent++;
      push_accept();
    end
    checks++; if (recv != 10 || exp_q.size() != 0) begin failures++;
      $display("FAIL stall_count got=%0d/%0d exp=10/0", recv, exp_q.size()); end
  endtask

  task automatic test_reset_inflight();
    for (int k = 0; k < 3; k++) begin
      rand_tick(1'b1, 1'b1);
      push_accept();
    end
    tick(1'b0, 1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
    exp_q.delete();
    tick(1'b1, 1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_fl_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_fl_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL rst_fl_out_data got=%h exp=0000", out_data); end
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b0, 16'h0, 4'h0, 2'b00, 1'b1);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_fl_stale k=%0d got=%h", k, out_data); end
    end
    single_op("post_rst_lsl", 16'h00FF, 4'd8, 2'b00, 16'hFF00);
  endtask

  task automatic test_random();
    res_t e;
    logic v, ordy;
    for (int t = 0; t < 340; t++) begin
      v    = (t < 300) && ($urandom_range(0, 9) < 7);
      ordy = (t >= 300) || ($urandom_range(0, 9) < 6);
      rand_tick(v, ordy);
      checks++; if (in_ready !== (ordy || exp_q.size() < SHW)) begin failures++;
        $display("FAIL rnd_in_ready t=%0d got=%b exp=%b", t, in_ready, (ordy || exp_q.size() < SHW)); end
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL rnd_stale t=%0d got=%h exp=none", t, out_data);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          checks++; if ({out_data, out_mode} !== {e.data, e.mode}) begin failures++;
            $display("FAIL rnd_data t=%0d got=%h/%b exp=%h/%b", t, out_data, out_mode, e.data, e.mode); end
        end
      end
      push_accept();
    end
    checks++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin failures++;
      $display("FAIL rnd_drain got=%0d/%b exp=0/0", exp_q.size(), out_valid); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_shamt = 4'h0; in_mode = 2'b00; out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
